// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and the instruction-queue entry layout for the fetch stage.
package inst_fetch_unit_pkg;
  localparam int DEF_IQ_DEPTH_BIT = 4;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic        is_c;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);
endpackage

// File: rtl/inst_fetch_unit_queue.sv
// Circular-buffer FIFO between fetch and decode; clear wins over push/pop.
module inst_queue #(
  parameter int DEPTH_BIT = 4,
  parameter int W         = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << DEPTH_BIT;

  logic [W-1:0]         mem [DEPTH];
  logic [DEPTH_BIT-1:0] head;
  logic [DEPTH_BIT-1:0] tail;
  logic [DEPTH_BIT:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (DEPTH_BIT + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = en && push && !full && !clear;
  assign do_pop  = en && pop && !empty && !clear;
  // Head is presented as zero when empty so the outputs read 0 after reset.
  assign dout    = empty ? '0 : mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + DEPTH_BIT'(1);
        if (do_pop)  head <= head + DEPTH_BIT'(1);
        count <= count + (DEPTH_BIT + 1)'(do_push) - (DEPTH_BIT + 1)'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: steps PC by 2/4, statically predicts JAL and backward branches,
// and buffers fetched instructions in a queue feeding the decoder.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          IQ_DEPTH_BIT = DEF_IQ_DEPTH_BIT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic [31:0] pc,
  output logic        inst_req,
  input  logic        inst_ready,
  input  logic [31:0] inst_res,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic        out_is_c,
  input  logic        out_pop
);
  logic        iq_full;
  logic        iq_empty;
  iq_entry_t   push_entry_p0;
  iq_entry_t   head_entry;
  logic        accept_p0;
  logic        is_c_p0;
  logic        pred_p0;
  logic [31:0] next_pc_p0;

  function automatic logic signed [31:0] sext_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] sext_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  assign inst_req  = rdy_in && !rst_in && !clear && !iq_full;
  assign accept_p0 = inst_req && inst_ready;
  assign is_c_p0   = (inst_res[1:0] != 2'b11);

  always_comb begin
    pred_p0    = 1'b0;
    next_pc_p0 = pc + 32'd4;
    if (is_c_p0) begin
      next_pc_p0 = pc + 32'd2;
    end else begin
      case (inst_res[6:0])
        OP_JAL: begin
          next_pc_p0 = $unsigned($signed(pc) + sext_j(inst_res));
          pred_p0    = 1'b1;
        end
        OP_BRANCH: begin
          // Backward branches (negative offset) are predicted taken.
          if (inst_res[31]) begin
            next_pc_p0 = $unsigned($signed(pc) + sext_b(inst_res));
            pred_p0    = 1'b1;
          end
        end
        OP_JALR: next_pc_p0 = pc + 32'd4;
        default: next_pc_p0 = pc + 32'd4;
      endcase
    end
  end

  assign push_entry_p0 = '{inst: inst_res, pc: pc, pred: pred_p0, is_c: is_c_p0};

  // pc only moves on an accepted hit or a redirect; a miss must hold it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc <= RESET_PC;
    end else if (rdy_in) begin
      if (clear)          pc <= clear_pc;
      else if (accept_p0) pc <= next_pc_p0;
    end
  end

  inst_queue #(
    .DEPTH_BIT (IQ_DEPTH_BIT),
    .W         (IQ_ENTRY_W)
  ) u_queue (
    .clk   (clk_in),
    .rst   (rst_in),
    .en    (rdy_in),
    .clear (clear),
    .push  (accept_p0),
    .pop   (out_pop),
    .din   (push_entry_p0),
    .dout  (head_entry),
    .full  (iq_full),
    .empty (iq_empty)
  );

  assign out_valid      = rdy_in && !iq_empty;
  assign out_inst       = head_entry.inst;
  assign out_pc         = head_entry.pc;
  assign out_pred_taken = head_entry.pred;
  assign out_is_c       = head_entry.is_c;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a queue-based reference model.
module tb_inst_fetch_unit;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] pc;
  logic        inst_req;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_res = 32'h0;
  logic        clear = 1'b0;
  logic [31:0] clear_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic        out_is_c;
  logic        out_pop = 1'b0;

  inst_fetch_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc(pc), .inst_req(inst_req),
    .inst_ready(inst_ready), .inst_res(inst_res), .clear(clear), .clear_pc(clear_pc),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .out_is_c(out_is_c), .out_pop(out_pop)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic        is_c;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_j(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'h63};
  endfunction

  // kind: 0 compressed, 1 jal, 2 branch, 3 jalr, 4 addi, 5 raw word given in off
  task automatic cyc(input logic r, input logic hit, input int kind, input int off,
                     input logic cl, input logic [31:0] cp, input logic pp);
    logic [31:0] word, tgt, rnd;
    logic        pr, ic, req;
    ent_t        e;
    rnd = $urandom();
    pr  = 1'b0;
    ic  = 1'b0;
    tgt = mpc + 32'd4;
    case (kind)
      0: begin
        word = {rnd[31:2], (rnd[1:0] == 2'b11) ? 2'b01 : rnd[1:0]};
        ic = 1'b1; tgt = mpc + 32'd2;
      end
      1: begin word = enc_j(off); pr = 1'b1; tgt = mpc + 32'(off); end
      2: begin
        word = enc_b(off);
        if (off < 0) begin pr = 1'b1; tgt = mpc + 32'(off); end
      end
      3: word = {rnd[31:7], 7'h67};
      4: word = {rnd[31:7], 7'h13};
      default: begin
        word = off;
        ic = (word[1:0] != 2'b11);
        tgt = ic ? mpc + 32'd2 : mpc + 32'd4;
      end
    endcase
    @(negedge clk_in);
    rdy_in = r; inst_ready = hit; inst_res = word; clear = cl; clear_pc = cp; out_pop = pp;
    #1;
    req = r && !cl && (mq.size() < 16);
    chk("inst_req", inst_req, req);
    chk("pc", pc, mpc);
    chk("out_valid", out_valid, r && (mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_pred_taken", out_pred_taken, mq[0].pred);
      chk("out_is_c", out_is_c, mq[0].is_c);
    end else begin
      chk("out_inst_empty", out_inst, 32'h0);
      chk("out_pc_empty", out_pc, 32'h0);
    end
    @(posedge clk_in);
    if (r) begin
      if (cl) begin
        mq.delete();
        mpc = cp;
      end else begin
        if (pp && mq.size() > 0) void'(mq.pop_front());
        if (req && hit) begin
          e = '{inst: word, pc: mpc, pred: pr, is_c: ic};
          mq.push_back(e);
          mpc = tgt;
        end
      end
    end
  endtask

  initial begin
    int kind, off;
    logic r, hit, cl, pp;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_inst_req", inst_req, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pred", out_pred_taken, 1'b0);
    chk("rst_out_is_c", out_is_c, 1'b0);
    rst_in = 1'b0;
    mpc = 32'h0;

    // sequential fill until full, then hold
    repeat (16) cyc(1, 1, 4, 0, 0, 0, 0);
    #1 chk("full_pc", pc, 32'h40);
    cyc(1, 1, 4, 0, 0, 0, 0);
    #1 chk("full_pc_hold", pc, 32'h40);
    cyc(1, 1, 4, 0, 0, 0, 1);
    cyc(1, 1, 4, 0, 0, 0, 1);
    #1 chk("refill_pc", pc, 32'h44);
    repeat (20) cyc(1, 1, 4, 0, 0, 0, 1);

    // compressed mix
    cyc(1, 0, 4, 0, 1, 32'h0, 0);
    cyc(1, 1, 5, 32'h0000_4505, 0, 0, 0);
    #1 chk("c_pc", pc, 32'h2);
    cyc(1, 1, 4, 0, 0, 0, 1);
    #1 chk("c_then_32_pc", pc, 32'h6);
    cyc(1, 0, 4, 0, 0, 0, 1);

    // prediction
    cyc(1, 0, 4, 0, 1, 32'h10, 0);
    cyc(1, 1, 1, 32'h100, 0, 0, 0);
    #1 chk("jal_pc", pc, 32'h110);
    chk("jal_pred", out_pred_taken, 1'b1);
    cyc(1, 0, 4, 0, 1, 32'h20, 0);
    cyc(1, 1, 2, -8, 0, 0, 0);
    #1 chk("beq_back_pc", pc, 32'h18);
    cyc(1, 0, 4, 0, 1, 32'h20, 0);
    cyc(1, 1, 2, 8, 0, 0, 0);
    #1 chk("beq_fwd_pc", pc, 32'h24);
    chk("beq_fwd_pred", out_pred_taken, 1'b0);
    cyc(1, 1, 3, 0, 0, 0, 1);
    #1 chk("jalr_pc", pc, 32'h28);

    // miss stall then a single hit
    repeat (20) cyc(1, 0, 4, 0, 0, 0, 0);
    cyc(1, 1, 4, 0, 0, 0, 0);
    #1 chk("stall_hit_pc", pc, 32'h2C);

    // clear with simultaneous pop and hit
    cyc(1, 0, 4, 0, 1, 32'h200, 0);
    repeat (5) cyc(1, 1, 4, 0, 0, 0, 0);
    cyc(1, 1, 4, 0, 1, 32'h80, 1);
    #1 chk("clear_pc", pc, 32'h80);
    chk("clear_valid", out_valid, 1'b0);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        1: off = (int'($urandom_range(0, 32'hFFFFF)) - 32'h80000) & ~1;
        2: off = (int'($urandom_range(0, 4095)) - 2048) & ~1;
        default: off = 0;
      endcase
      r   = ($urandom_range(0, 9) != 0);
      hit = ($urandom_range(0, 3) != 0);
      cl  = ($urandom_range(0, 39) == 0);
      pp  = (n % 400 < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      cyc(r, hit, kind, off, cl, $urandom() & 32'hFFFF_FFFE, pp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
